// File: rtl/cva6_lsu_mem_pkg.sv
// Shared types and constants for the CVA6 LSU memory-side responder.
package cva6_lsu_mem_pkg;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_WAIT = 1'b1
    } ld_state_e;

    localparam int unsigned MIN_LAT = 1;

endpackage

// File: rtl/cva6_lsu_store_queue.sv
// In-order store queue; only the head entry counts down its own latency and pops on its pulse.
module cva6_lsu_store_queue
    import cva6_lsu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LAT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [LAT_W-1:0]  push_lat_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              resp_o,
    output logic [ADDR_W-1:0] resp_addr_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LAT_W-1:0]  lat;
    } st_entry_t;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    st_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [LAT_W-1:0]  r_head_cnt;
    logic              r_resp;
    logic [ADDR_W-1:0] r_resp_addr;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_rd_next;
    logic [LAT_W-1:0]  w_head_cnt_nxt;

    assign full_o      = (r_count == CNT_W'(DEPTH));
    assign empty_o     = (r_count == '0);
    assign resp_o      = r_resp;
    assign resp_addr_o = r_resp_addr;

    assign w_push    = push_i && !full_o;
    assign w_pop     = !empty_o && (r_head_cnt == LAT_W'(MIN_LAT));
    assign w_rd_next = r_rd_ptr + PTR_W'(1);

    // The head counter reloads whenever a new entry becomes head: push into
    // an empty queue, or pop with a successor (already stored or arriving now).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_head_cnt_nxt = r_head_cnt;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_cnt_nxt = r_mem[w_rd_next].lat;
            end else if (w_push) begin
                w_head_cnt_nxt = push_lat_i;
            end else begin
                w_head_cnt_nxt = '0;
            end
        end else if (w_push && empty_o) begin
            w_head_cnt_nxt = push_lat_i;
        end else if (r_head_cnt > LAT_W'(MIN_LAT)) begin
            w_head_cnt_nxt = r_head_cnt - LAT_W'(1);
        end
    end

    // NOTE: entry storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: push_addr_i, lat: push_lat_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_cnt  <= '0;
            r_resp      <= 1'b0;
            r_resp_addr <= '0;
        end else begin
            r_head_cnt  <= w_head_cnt_nxt;
            r_resp      <= w_pop;
            r_resp_addr <= w_pop ? r_mem[r_rd_ptr].addr : '0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder: one load slot with a countdown FSM plus an in-order store queue.
module cva6_lsu_mem_responder
    import cva6_lsu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned STORE_DEPTH = 2,
    parameter int unsigned LAT_W       = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              req_is_load_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    input  logic [LAT_W-1:0]  cfg_load_lat_i,
    input  logic [LAT_W-1:0]  cfg_store_lat_i,
    output logic              load_mem_resp_o,
    output logic [ADDR_W-1:0] load_resp_addr_o,
    output logic              store_mem_resp_o,
    output logic [ADDR_W-1:0] store_resp_addr_o,
    output logic              busy_o
);

    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] cfg);
        return (cfg < LAT_W'(MIN_LAT)) ? LAT_W'(MIN_LAT) : cfg;
    endfunction

    ld_state_e         r_ld_state;
    logic [LAT_W-1:0]  r_ld_cnt;
    logic [ADDR_W-1:0] r_ld_addr;
    logic              r_ld_resp;
    logic [ADDR_W-1:0] r_ld_resp_addr;

    ld_state_e         w_ld_state_nxt;
    logic [LAT_W-1:0]  w_ld_cnt_nxt;
    logic [ADDR_W-1:0] w_ld_addr_nxt;
    logic              w_ld_resp_nxt;
    logic [ADDR_W-1:0] w_ld_resp_addr_nxt;

    logic w_ld_busy;
    logic w_st_full;
    logic w_st_empty;
    logic w_ready;
    logic w_ld_push;
    logic w_st_push;

    // The pulse cycle still counts as busy, so a new load cannot overlap its own response.
    assign w_ld_busy = (r_ld_state == LD_WAIT) || r_ld_resp;
    assign w_ready   = !w_ld_busy && !w_st_full;
    assign w_ld_push = req_valid_i && w_ready && req_is_load_i;
    assign w_st_push = req_valid_i && w_ready && !req_is_load_i;

    assign req_ready_o      = w_ready;
    assign busy_o           = w_ld_busy || !w_st_empty;
    assign load_mem_resp_o  = r_ld_resp;
    assign load_resp_addr_o = r_ld_resp_addr;

    always_comb begin
        w_ld_state_nxt     = r_ld_state;
        w_ld_cnt_nxt       = r_ld_cnt;
        w_ld_addr_nxt      = r_ld_addr;
        w_ld_resp_nxt      = 1'b0;
        w_ld_resp_addr_nxt = '0;
        case (r_ld_state)
            LD_IDLE: begin
                if (w_ld_push) begin
                    w_ld_state_nxt = LD_WAIT;
                    w_ld_cnt_nxt   = eff_lat(cfg_load_lat_i);
                    w_ld_addr_nxt  = req_addr_i;
                end
            end
            LD_WAIT: begin
                if (r_ld_cnt <= LAT_W'(MIN_LAT)) begin
                    w_ld_state_nxt     = LD_IDLE;
                    w_ld_cnt_nxt       = '0;
                    w_ld_resp_nxt      = 1'b1;
                    w_ld_resp_addr_nxt = r_ld_addr;
                end else begin
                    w_ld_cnt_nxt = r_ld_cnt - LAT_W'(1);
                end
            end
            default: w_ld_state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ld_state     <= LD_IDLE;
            r_ld_cnt       <= '0;
            r_ld_addr      <= '0;
            r_ld_resp      <= 1'b0;
            r_ld_resp_addr <= '0;
        end else begin
            r_ld_state     <= w_ld_state_nxt;
            r_ld_cnt       <= w_ld_cnt_nxt;
            r_ld_addr      <= w_ld_addr_nxt;
            r_ld_resp      <= w_ld_resp_nxt;
            r_ld_resp_addr <= w_ld_resp_addr_nxt;
        end
    end

    cva6_lsu_store_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STORE_DEPTH),
        .LAT_W  (LAT_W)
    ) u_store_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_st_push),
        .push_addr_i (req_addr_i),
        .push_lat_i  (eff_lat(cfg_store_lat_i)),
        .full_o      (w_st_full),
        .empty_o     (w_st_empty),
        .resp_o      (store_mem_resp_o),
        .resp_addr_o (store_resp_addr_o)
    );

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Directed bench for cva6_lsu_mem_responder: stimulus pushes expected pulses, a monitor checks them.
module tb_cva6_lsu_mem_responder;

    localparam int ADDR_W = 32;
    localparam int LAT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_is_load_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_ready_o;
    logic [LAT_W-1:0]  cfg_load_lat_i;
    logic [LAT_W-1:0]  cfg_store_lat_i;
    logic              load_mem_resp_o;
    logic [ADDR_W-1:0] load_resp_addr_o;
    logic              store_mem_resp_o;
    logic [ADDR_W-1:0] store_resp_addr_o;
    logic              busy_o;

    cva6_lsu_mem_responder #(
        .ADDR_W      (ADDR_W),
        .STORE_DEPTH (2),
        .LAT_W       (LAT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_is_load_i     (req_is_load_i),
        .req_addr_i        (req_addr_i),
        .req_ready_o       (req_ready_o),
        .cfg_load_lat_i    (cfg_load_lat_i),
        .cfg_store_lat_i   (cfg_store_lat_i),
        .load_mem_resp_o   (load_mem_resp_o),
        .load_resp_addr_o  (load_resp_addr_o),
        .store_mem_resp_o  (store_mem_resp_o),
        .store_resp_addr_o (store_resp_addr_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // cyc equals k during the cycle that follows rising edge k.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } exp_t;

    exp_t ld_q[$];
    exp_t st_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ld_q.size() > 0 && ld_q[0].cyc == cyc) begin
                check("load_pulse", load_mem_resp_o, 1);
                check("load_resp_addr", load_resp_addr_o, ld_q[0].addr);
                void'(ld_q.pop_front());
            end else begin
                check("load_no_pulse", load_mem_resp_o, 0);
                check("load_addr_idle", load_resp_addr_o, 0);
            end
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                check("store_pulse", store_mem_resp_o, 1);
                check("store_resp_addr", store_resp_addr_o, st_q[0].addr);
                void'(st_q.pop_front());
            end else begin
                check("store_no_pulse", store_mem_resp_o, 0);
                check("store_addr_idle", store_resp_addr_o, 0);
            end
        end
    end

    // Called just after a falling edge; the request is seen by the next rising edge.
    // delay is the hand-computed number of cycles from that accept edge to the pulse.
    task automatic issue(input logic is_ld, input logic [ADDR_W-1:0] addr, input logic [LAT_W-1:0] lat,
                         input logic exp_rdy, input int delay);
        exp_t e;
        req_valid_i   = 1'b1;
        req_is_load_i = is_ld;
        req_addr_i    = addr;
        if (is_ld) cfg_load_lat_i = lat;
        else       cfg_store_lat_i = lat;
        check(is_ld ? "ready_for_load" : "ready_for_store", req_ready_o, exp_rdy);
        if (exp_rdy) begin
            e.addr = addr;
            e.cyc  = cyc + 1 + delay;
            if (is_ld) ld_q.push_back(e);
            else       st_q.push_back(e);
        end
        @(negedge clk_i);
        req_valid_i   = 1'b0;
        req_is_load_i = 1'b0;
        req_addr_i    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = 1'b0;
        req_is_load_i   = 1'b0;
        req_addr_i      = '0;
        cfg_load_lat_i  = '0;
        cfg_store_lat_i = '0;
        #2;
        check("rst_ready", req_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_load_resp", load_mem_resp_o, 0);
        check("rst_store_resp", store_mem_resp_o, 0);
        check("rst_load_addr", load_resp_addr_o, 0);
        check("rst_store_addr", store_resp_addr_o, 0);
        idle(2);
        rst_ni = 1'b1;
        idle(2);

        // Load, L=3: ready low from the accept through the pulse cycle.
        issue(1'b1, 32'hcad, 4'd3, 1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            check("ld3_ready_low", req_ready_o, 0);
            check("ld3_busy", busy_o, 1);
            idle(1);
        end
        check("ld3_ready_back", req_ready_o, 1);
        check("ld3_busy_clear", busy_o, 0);
        idle(1);

        // Latency 0 behaves exactly like latency 1; then maximum latency.
        issue(1'b1, 32'h0a0, 4'd0, 1'b1, 1);
        idle(2);
        issue(1'b1, 32'h0a4, 4'd1, 1'b1, 1);
        idle(2);
        issue(1'b1, 32'h0a8, 4'd15, 1'b1, 15);
        idle(16);

        // Store queue L=2: second waits for the first, third refused while full.
        issue(1'b0, 32'h100, 4'd2, 1'b1, 2);
        issue(1'b0, 32'h104, 4'd2, 1'b1, 3);
        issue(1'b0, 32'h108, 4'd2, 1'b0, 0);
        issue(1'b0, 32'h108, 4'd2, 1'b1, 3);
        idle(5);

        // L=1 chain: pop and push land on the same edge twice in a row.
        issue(1'b0, 32'h600, 4'd1, 1'b1, 1);
        issue(1'b0, 32'h604, 4'd1, 1'b1, 1);
        issue(1'b0, 32'h608, 4'd1, 1'b1, 1);
        idle(3);

        // Concurrency: store then load on consecutive edges, then coinciding pulses.
        issue(1'b0, 32'h700, 4'd4, 1'b1, 4);
        issue(1'b1, 32'h704, 4'd4, 1'b1, 4);
        idle(6);
        issue(1'b0, 32'h710, 4'd4, 1'b1, 4);
        issue(1'b1, 32'h714, 4'd3, 1'b1, 3);
        idle(6);

        // Drop: requests while the load is outstanding are ignored.
        issue(1'b1, 32'h200, 4'd3, 1'b1, 3);
        issue(1'b1, 32'h300, 4'd3, 1'b0, 0);
        issue(1'b0, 32'h304, 4'd3, 1'b0, 0);
        idle(1);
        check("drop_busy_pulse_cycle", busy_o, 1);
        idle(1);
        check("drop_busy_after_pulse", busy_o, 0);
        check("drop_ready_after_pulse", req_ready_o, 1);
        idle(2);

        // Reset one cycle before the expected pulse: nothing may come out.
        issue(1'b1, 32'h400, 4'd4, 1'b1, 4);
        issue(1'b0, 32'h404, 4'd4, 1'b0, 0);
        idle(2);
        #1;
        rst_ni = 1'b0;
        ld_q.delete();
        st_q.delete();
        #1;
        check("midrst_ready", req_ready_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_load_resp", load_mem_resp_o, 0);
        @(posedge clk_i);
        #1;
        check("midrst_no_pulse", load_mem_resp_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(1);
        issue(1'b1, 32'h500, 4'd2, 1'b1, 2);
        issue(1'b0, 32'h504, 4'd2, 1'b0, 0);
        idle(4);
        issue(1'b0, 32'h508, 4'd2, 1'b1, 2);
        idle(4);

        check("load_scoreboard_drained", ld_q.size(), 0);
        check("store_scoreboard_drained", st_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
